// File: rtl/slave_board_ctrl_pkg.sv
// Shared definitions for the player-B board controller.
// Contents:
//   disp_word_e     - display word codes forwarded to B's display driver
//   DEB_CYCLES_DEF  - default debounce length (stable samples)
//   popcount16      - number of set bits in a 16-bit board word
package slave_board_ctrl_pkg;

  typedef enum logic [2:0] {
    DISP_BLANK  = 3'd0,
    DISP_SHIPS  = 3'd1,
    DISP_ATTACK = 3'd2,
    DISP_HITS   = 3'd3,
    DISP_OK     = 3'd4,
    DISP_WIN    = 3'd5,
    DISP_LOSE   = 3'd6,
    DISP_CLEAR  = 3'd7
  } disp_word_e;

  localparam int DEB_CYCLES_DEF = 250000;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/slave_board_ctrl_if.sv
// Link between the master board (game FSM) and the player-B slave board.
// master modport: drives clr/ldr1/ldr2/st/disp/a_attack, receives requests,
//                 b_attack, ok, liv, word_sel and hits_taken.
// slave modport:  the mirror image, used by slave_board_ctrl.
interface slave_board_ctrl_if #(parameter int W = 16);

  logic         clr;
  logic         ldr1;
  logic         ldr2;
  logic         st;
  logic [2:0]   disp;
  logic [W-1:0] a_attack;
  logic         btn1_req;
  logic         btn2_req;
  logic         btn3_req;
  logic [W-1:0] b_attack;
  logic         ok;
  logic         liv;
  logic [2:0]   word_sel;
  logic [4:0]   hits_taken;

  modport master (
    output clr, ldr1, ldr2, st, disp, a_attack,
    input  btn1_req, btn2_req, btn3_req, b_attack, ok, liv, word_sel, hits_taken
  );

  modport slave (
    input  clr, ldr1, ldr2, st, disp, a_attack,
    output btn1_req, btn2_req, btn3_req, b_attack, ok, liv, word_sel, hits_taken
  );

endinterface

// File: rtl/slave_board_ctrl_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, debouncer and request FSM.
// Ports:
//   clk       - system clock
//   clr_n     - sync active-low local reset (clears everything)
//   clr       - sync active-high game clear (request FSM only)
//   btn_raw_i - asynchronous button input
//   ack_i     - master acknowledge for this button's request
//   req_o     - registered request level, held until acknowledged
module btn_conditioner #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic btn_raw_i,
  input  logic ack_i,
  output logic req_o
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} req_state_e;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic          deb_q, deb_prev_q;
  logic          rise;
  req_state_e    state_q;
  logic          req_q;

  // The debounce state survives a game clear, so a button still held across
  // clr keeps deb_prev_q high and cannot fake a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;  // any sample matching the current level restarts the count
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  // Ack is only honoured in REQ, so an ack coinciding with the rise is ignored.
  always_ff @(posedge clk) begin
    if (!clr_n || clr) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: if (ack_i) begin
          state_q <= WAIT_REL;
          req_q   <= 1'b0;
        end
        WAIT_REL: if (!deb_q) state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/slave_board_ctrl.sv
// Player-B (slave) board controller: button requests to the master, B's ship
// and attack registers, damage from A's attack word, and ok/liv status.
// Ports:
//   clk, clr_n          - system clock, sync active-low local reset
//   sw                  - B switches (ship layout or attack selection)
//   btn1/2/3_raw        - asynchronous load/fire/clear buttons
//   bus (slave modport) - master link: clr, ldr1, ldr2, st, disp, a_attack in;
//                         btnN_req, b_attack, ok, liv, word_sel, hits_taken out
// Optional feature macro: BS_HIT_COUNT_EN enables the saturating hit counter;
// without it hits_taken is tied to zero.
module slave_board_ctrl
  import slave_board_ctrl_pkg::*;
#(
  parameter int W          = 16,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [W-1:0]    sw,
  input  logic            btn1_raw,
  input  logic            btn2_raw,
  input  logic            btn3_raw,
  slave_board_ctrl_if.slave bus
);

  logic [W-1:0] ships_q, prev_att_q, b_attack_q;
  logic         ok_q, liv_q;
  disp_word_e   word_sel_q;
  logic [W-1:0] new_bits, lost_bits;
  logic         ok_d;
  logic         game_rst;

  assign game_rst = ~clr_n | bus.clr;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn1 (
    .clk(clk), .clr_n(clr_n), .clr(bus.clr),
    .btn_raw_i(btn1_raw), .ack_i(bus.ldr1), .req_o(bus.btn1_req)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn2 (
    .clk(clk), .clr_n(clr_n), .clr(bus.clr),
    .btn_raw_i(btn2_raw), .ack_i(bus.ldr2), .req_o(bus.btn2_req)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn3 (
    .clk(clk), .clr_n(clr_n), .clr(bus.clr),
    .btn_raw_i(btn3_raw), .ack_i(bus.clr), .req_o(bus.btn3_req)
  );

  // A's move is legal when exactly one new cell appears and no previously
  // attacked cell has disappeared from the cumulative word.
  always_comb begin
    new_bits  = bus.a_attack & ~prev_att_q;
    lost_bits = prev_att_q & ~bus.a_attack;
    ok_d      = (popcount16(16'(new_bits)) == 5'd1) && (lost_bits == '0);
  end

  always_ff @(posedge clk) begin
    if (game_rst) begin
      ships_q    <= '0;
      prev_att_q <= '0;
      b_attack_q <= '0;
      ok_q       <= 1'b0;
      liv_q      <= 1'b0;
      word_sel_q <= DISP_BLANK;
    end else begin
      word_sel_q <= disp_word_e'(bus.disp);
      ok_q       <= ok_d;
      liv_q      <= |ships_q;
      if (bus.ldr1) begin
        if (bus.st) begin
          ships_q    <= ships_q & ~bus.a_attack;
          prev_att_q <= bus.a_attack;
        end else begin
          ships_q    <= sw;
          prev_att_q <= '0;
        end
      end
      if (bus.ldr2) b_attack_q <= sw;
    end
  end

  assign bus.b_attack = b_attack_q;
  assign bus.ok       = ok_q;
  assign bus.liv      = liv_q;
  assign bus.word_sel = word_sel_q;

`ifdef BS_HIT_COUNT_EN
  logic [4:0] hits_q;
  logic [5:0] hits_sum_d;

  // Hits are counted against the ship layout before this volley's damage.
  assign hits_sum_d = {1'b0, hits_q} + {1'b0, popcount16(16'(ships_q & bus.a_attack))};

  always_ff @(posedge clk) begin
    if (game_rst) begin
      hits_q <= '0;
    end else if (bus.ldr1 && bus.st) begin
      hits_q <= (hits_sum_d > 6'd16) ? 5'd16 : hits_sum_d[4:0];
    end
  end

  assign bus.hits_taken = hits_q;
`else
  assign bus.hits_taken = 5'd0;
`endif

endmodule

// File: tb/tb_slave_board_ctrl.sv
module tb_slave_board_ctrl;

  localparam int W   = 16;
  localparam int DEB = 4;
  localparam int REQ_LAT = 2 + DEB + 1;  // sync + debounce + registered FSM output

`ifdef BS_HIT_COUNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  typedef enum int {S_SHIPS, S_PREV, S_BATT, S_OK, S_LIV, S_WSEL, S_HITS,
                    S_REQ1, S_REQ2, S_REQ3} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] exp;
    int          due;
  } sb_t;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [W-1:0] sw;
  logic         btn1_raw, btn2_raw, btn3_raw;

  slave_board_ctrl_if #(.W(W)) bus ();

  slave_board_ctrl #(.W(W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .clr_n(clr_n), .sw(sw),
    .btn1_raw(btn1_raw), .btn2_raw(btn2_raw), .btn3_raw(btn3_raw),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  sb_t sbq[$];
  int  exp_hits = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [15:0] observe(input sel_e s);
    case (s)
      S_SHIPS: return dut.ships_q;
      S_PREV:  return dut.prev_att_q;
      S_BATT:  return bus.b_attack;
      S_OK:    return {15'd0, bus.ok};
      S_LIV:   return {15'd0, bus.liv};
      S_WSEL:  return {13'd0, bus.word_sel};
      S_HITS:  return {11'd0, bus.hits_taken};
      S_REQ1:  return {15'd0, bus.btn1_req};
      S_REQ2:  return {15'd0, bus.btn2_req};
      default: return {15'd0, bus.btn3_req};
    endcase
  endfunction

  task automatic expect_at(input string tag, input sel_e s, input logic [15:0] v, input int lat);
    sb_t e;
    e.tag = tag; e.sel = s; e.exp = v; e.due = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic expect_span(input string tag, input sel_e s, input logic [15:0] v,
                             input int lo, input int hi);
    for (int l = lo; l <= hi; l++) expect_at(tag, s, v, l);
  endtask

  task automatic expect_hits(input string tag, input logic [15:0] ships, input logic [15:0] att);
    exp_hits = exp_hits + $countones(ships & att);
    if (exp_hits > 16) exp_hits = 16;
    expect_at(tag, S_HITS, HIT_EN ? 16'(exp_hits) : 16'd0, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare every expectation that falls due on this edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    begin
      int i;
      i = 0;
      while (i < sbq.size()) begin
        if (sbq[i].due == cyc) begin
          check(sbq[i].tag, observe(sbq[i].sel), sbq[i].exp);
          sbq.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with loads and display asserted: nothing may leak through.
    clr_n = 1'b0; bus.clr = 1'b0; bus.ldr1 = 1'b1; bus.ldr2 = 1'b1; bus.st = 1'b0;
    bus.disp = 3'd5; bus.a_attack = '0; sw = 16'hFFFF;
    btn1_raw = 1'b0; btn2_raw = 1'b0; btn3_raw = 1'b0;
    expect_at("rst_ships", S_SHIPS, 16'h0, 1);
    expect_at("rst_batt",  S_BATT,  16'h0, 1);
    expect_at("rst_wsel",  S_WSEL,  16'h0, 1);
    expect_at("rst_ok",    S_OK,    16'h0, 1);
    expect_at("rst_liv",   S_LIV,   16'h0, 1);
    expect_at("rst_req1",  S_REQ1,  16'h0, 1);
    expect_at("rst_hits",  S_HITS,  16'h0, 1);
    step(2);

    clr_n = 1'b1; bus.ldr1 = 1'b0; bus.ldr2 = 1'b0; sw = '0; bus.disp = 3'd6;
    expect_at("wsel_6", S_WSEL, 16'd6, 1);
    expect_at("idle_ships", S_SHIPS, 16'h0, 1);
    step(1);

    // Setup ship load.
    bus.disp = 3'd2; sw = 16'h00F0; bus.ldr1 = 1'b1;
    expect_at("wsel_2", S_WSEL, 16'd2, 1);
    expect_at("load_ships", S_SHIPS, 16'h00F0, 1);
    expect_at("load_prev", S_PREV, 16'h0000, 1);
    expect_at("load_ok0", S_OK, 16'h0, 1);
    expect_at("load_liv", S_LIV, 16'h1, 2);
    step(1);

    // First attack from A: one hit.
    bus.st = 1'b1; bus.a_attack = 16'h0010;
    expect_at("dmg_ships", S_SHIPS, 16'h00E0, 1);
    expect_at("dmg_prev", S_PREV, 16'h0010, 1);
    expect_at("dmg_ok", S_OK, 16'h1, 1);
    expect_at("dmg_liv", S_LIV, 16'h1, 2);
    expect_hits("hits_1", 16'h00F0, 16'h0010);
    step(1);

    // ok against prev_att = 0010.
    bus.ldr1 = 1'b0; bus.a_attack = 16'h0030;
    expect_at("ok_one_new", S_OK, 16'h1, 1);
    step(1);
    bus.a_attack = 16'h0070; expect_at("ok_two_new", S_OK, 16'h0, 1); step(1);
    bus.a_attack = 16'h0020; expect_at("ok_lost", S_OK, 16'h0, 1); step(1);
    bus.a_attack = 16'h0010; expect_at("ok_same", S_OK, 16'h0, 1); step(1);
    bus.a_attack = 16'h0000; expect_at("ok_cleared", S_OK, 16'h0, 1); step(1);

    // Sink the last ship.
    bus.st = 1'b0; sw = 16'h0001; bus.ldr1 = 1'b1;
    expect_at("ld1_ships", S_SHIPS, 16'h0001, 1);
    expect_at("ld1_prev", S_PREV, 16'h0000, 1);
    step(1);
    bus.st = 1'b1; bus.a_attack = 16'h0001;
    expect_at("sink_ships", S_SHIPS, 16'h0000, 1);
    expect_at("sink_ok", S_OK, 16'h1, 1);
    expect_at("sink_liv", S_LIV, 16'h0, 2);
    expect_hits("hits_2", 16'h0001, 16'h0001);
    step(1);

    // Hit counter saturation.
    bus.st = 1'b0; sw = 16'hFFFF;
    expect_at("full_ships", S_SHIPS, 16'hFFFF, 1);
    expect_at("full_liv", S_LIV, 16'h1, 2);
    step(1);
    bus.st = 1'b1; bus.a_attack = 16'hFFFF;
    expect_at("wipe_ships", S_SHIPS, 16'h0000, 1);
    expect_hits("hits_sat", 16'hFFFF, 16'hFFFF);
    step(1);
    bus.st = 1'b0;
    step(1);
    bus.st = 1'b1;
    expect_hits("hits_sat2", 16'hFFFF, 16'hFFFF);
    expect_at("wipe2_liv", S_LIV, 16'h0, 2);
    step(1);

    // Simultaneous ship and attack loads.
    bus.st = 1'b0; bus.a_attack = '0; sw = 16'h8001; bus.ldr1 = 1'b1; bus.ldr2 = 1'b1;
    expect_at("both_ships", S_SHIPS, 16'h8001, 1);
    expect_at("both_batt", S_BATT, 16'h8001, 1);
    step(1);
    bus.ldr1 = 1'b0; sw = 16'h1234;
    expect_at("ldr2_batt", S_BATT, 16'h1234, 1);
    expect_at("ldr2_ships", S_SHIPS, 16'h8001, 1);
    step(1);
    bus.ldr2 = 1'b0; sw = 16'h8001;

    // Bouncing press on btn1, then held.
    btn1_raw = 1'b1; step(1);
    btn1_raw = 1'b0; step(1);
    btn1_raw = 1'b1;
    expect_span("req1_early", S_REQ1, 16'h0, 1, REQ_LAT - 1);
    expect_at("req1_rise", S_REQ1, 16'h1, REQ_LAT);
    step(REQ_LAT);
    bus.ldr1 = 1'b1;
    expect_span("req1_ack", S_REQ1, 16'h0, 1, 12);
    step(1);
    bus.ldr1 = 1'b0;
    step(12);
    btn1_raw = 1'b0;
    expect_span("req1_rel", S_REQ1, 16'h0, 1, 10);
    step(10);
    btn1_raw = 1'b1;
    expect_at("req1_again_lo", S_REQ1, 16'h0, REQ_LAT - 1);
    expect_at("req1_again", S_REQ1, 16'h1, REQ_LAT);
    step(REQ_LAT);

    // Game clear while a request is pending and the button is held.
    bus.clr = 1'b1;
    expect_at("clr_ships", S_SHIPS, 16'h0, 1);
    expect_at("clr_prev", S_PREV, 16'h0, 1);
    expect_at("clr_batt", S_BATT, 16'h0, 1);
    expect_at("clr_ok", S_OK, 16'h0, 1);
    expect_at("clr_liv", S_LIV, 16'h0, 1);
    expect_at("clr_wsel", S_WSEL, 16'h0, 1);
    expect_at("clr_hits", S_HITS, 16'h0, 1);
    expect_at("clr_req1", S_REQ1, 16'h0, 1);
    step(1);
    bus.clr = 1'b0; exp_hits = 0;
    expect_span("clr_held", S_REQ1, 16'h0, 1, 12);
    step(12);
    btn1_raw = 1'b0;
    step(8);
    btn1_raw = 1'b1;
    expect_at("req1_post_clr", S_REQ1, 16'h1, REQ_LAT);
    step(REQ_LAT + 1);

    // btn2 acked by ldr2, btn3 acked by clr.
    btn2_raw = 1'b1;
    expect_at("req2_rise", S_REQ2, 16'h1, REQ_LAT);
    step(REQ_LAT);
    sw = 16'h0F0F; bus.ldr2 = 1'b1;
    expect_at("req2_ack", S_REQ2, 16'h0, 1);
    expect_at("req2_batt", S_BATT, 16'h0F0F, 1);
    step(1);
    bus.ldr2 = 1'b0; btn2_raw = 1'b0;
    step(2);
    btn3_raw = 1'b1;
    expect_at("req3_rise", S_REQ3, 16'h1, REQ_LAT);
    step(REQ_LAT);
    bus.clr = 1'b1;
    expect_at("req3_ack", S_REQ3, 16'h0, 1);
    step(1);
    bus.clr = 1'b0;
    expect_span("req3_held", S_REQ3, 16'h0, 1, 6);
    step(8);

    if (sbq.size() != 0) check("sb_drain", 16'(sbq.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
